// File: rtl/rvfi_trace_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_trace_serializer (plus rvfi_trace_serializer_pkg)
// Description : Consumer end of the RVFI retirement interface. Valid commit
//               lanes are compacted in lane order into a DEPTH-entry FIFO and
//               drained one record per cycle over a valid/ready stream. The
//               core is never back-pressured: a group that does not fit is
//               dropped whole and counted. Commit-order continuity is checked
//               on every accepted record.
// Ports       : clk_i, rst_ni (sync, active low)
//               rvfi_i            NRET-lane commit vector
//               out_valid_o/out_ready_i, out_* head record fields
//               overflow_o, drop_cnt_o   drop reporting (sticky / saturating)
//               order_err_o, exp_order_o order-continuity reporting
// Option      : `define RVFI_SER_TIMESTAMP_EN adds a 32-bit free-running cycle
//               stamp per record, presented on out_tstamp_o.
// Revision    : 1.0 - initial release
// ============================================================================

package rvfi_trace_serializer_pkg;
  localparam int unsigned RVFI_XLEN = 64;
  localparam int unsigned RVFI_ILEN = 32;

  // Payload stored per FIFO entry.
  typedef struct packed {
    logic [63:0]            order;
    logic [RVFI_ILEN-1:0]   insn;
    logic                   trap;
    logic [RVFI_XLEN-1:0]   pc_rdata;
    logic [4:0]             rd_addr;
    logic [RVFI_XLEN-1:0]   rd_wdata;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_XLEN/8-1:0] mem_wmask;
  } rvfi_rec_t;

  // One retire lane as emitted by the core.
  typedef struct packed {
    logic      valid;
    rvfi_rec_t rec;
  } rvfi_instr_t;
endpackage

module rvfi_trace_serializer
  import rvfi_trace_serializer_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = RVFI_XLEN,
  parameter int unsigned ILEN  = RVFI_ILEN,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  rvfi_instr_t [NRET-1:0]  rvfi_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [63:0]             out_order_o,
  output logic [ILEN-1:0]         out_insn_o,
  output logic                    out_trap_o,
  output logic [XLEN-1:0]         out_pc_o,
  output logic [4:0]              out_rd_addr_o,
  output logic [XLEN-1:0]         out_rd_wdata_o,
  output logic [XLEN-1:0]         out_mem_addr_o,
  output logic [XLEN/8-1:0]       out_mem_wmask_o,
`ifdef RVFI_SER_TIMESTAMP_EN
  output logic [31:0]             out_tstamp_o,
`endif
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o,
  output logic                    order_err_o,
  output logic [63:0]             exp_order_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned KW = $clog2(NRET + 1);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_e;

  rvfi_rec_t   mem_q [DEPTH];
  rvfi_rec_t   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  trk_state_e  st_q, st_d;
  logic [63:0] next_order_q, next_order_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        order_err_q, order_err_d;
  logic [63:0] exp_order_q, exp_order_d;

  logic [KW-1:0] k;
  logic [KW-1:0] pushed;
  logic          pop;
  logic [CW:0]   free;
  logic          accept;
  logic [PW-1:0] slot;
  logic [16:0]   drop_sum;

`ifdef RVFI_SER_TIMESTAMP_EN
  logic [31:0] tstamp_q, tstamp_d;
  logic [31:0] ts_mem_q [DEPTH];
  logic [31:0] ts_mem_d [DEPTH];
`endif

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    st_d         = st_q;
    next_order_d = next_order_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    order_err_d  = order_err_q;
    exp_order_d  = exp_order_q;
    pushed       = '0;
    slot         = wr_ptr_q;
`ifdef RVFI_SER_TIMESTAMP_EN
    tstamp_d     = tstamp_q + 32'd1;
    ts_mem_d     = ts_mem_q;
`endif

    k = '0;
    for (int unsigned l = 0; l < NRET; l++) begin
      k = k + KW'(rvfi_i[l].valid);
    end

    // A pop in the same cycle frees its slot for this cycle's push.
    pop      = (count_q != '0) & out_ready_i;
    free     = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
    accept   = ((CW+1)'(k) <= free);
    drop_sum = {1'b0, drop_cnt_q} + 17'(k);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (k != '0) begin
      if (accept) begin
        pushed = k;
        // Holes compress: each valid lane takes the next free slot, and the
        // tracker walks lanes in order so lane j is checked against lane j-1.
        for (int unsigned l = 0; l < NRET; l++) begin
          if (rvfi_i[l].valid) begin
            mem_d[slot] = rvfi_i[l].rec;
`ifdef RVFI_SER_TIMESTAMP_EN
            ts_mem_d[slot] = tstamp_q;
`endif
            if (st_d == ST_TRACK && rvfi_i[l].rec.order != next_order_d && !order_err_d) begin
              order_err_d = 1'b1;
              exp_order_d = next_order_d;
            end
            st_d         = ST_TRACK;
            next_order_d = rvfi_i[l].rec.order + 64'd1;
            slot         = slot + PW'(1);
          end
        end
        wr_ptr_d = slot;
      end else begin
        // Whole group dropped; the next accepted record resynchronises.
        overflow_d = 1'b1;
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        st_d       = ST_FIRST;
      end
    end

    count_d = count_q + CW'(pushed) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef RVFI_SER_TIMESTAMP_EN
        ts_mem_q[i] <= '0;
`endif
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      st_q         <= ST_FIRST;
      next_order_q <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      order_err_q  <= 1'b0;
      exp_order_q  <= '0;
`ifdef RVFI_SER_TIMESTAMP_EN
      tstamp_q     <= '0;
`endif
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      st_q         <= st_d;
      next_order_q <= next_order_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      order_err_q  <= order_err_d;
      exp_order_q  <= exp_order_d;
`ifdef RVFI_SER_TIMESTAMP_EN
      ts_mem_q     <= ts_mem_d;
      tstamp_q     <= tstamp_d;
`endif
    end
  end

  rvfi_rec_t head;
  assign head = mem_q[rd_ptr_q];

  assign out_valid_o     = (count_q != '0);
  assign out_order_o     = head.order;
  assign out_insn_o      = head.insn;
  assign out_trap_o      = head.trap;
  assign out_pc_o        = head.pc_rdata;
  assign out_rd_addr_o   = head.rd_addr;
  assign out_rd_wdata_o  = head.rd_wdata;
  assign out_mem_addr_o  = head.mem_addr;
  assign out_mem_wmask_o = head.mem_wmask;
`ifdef RVFI_SER_TIMESTAMP_EN
  assign out_tstamp_o    = ts_mem_q[rd_ptr_q];
`endif
  assign overflow_o      = overflow_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign order_err_o     = order_err_q;
  assign exp_order_o     = exp_order_q;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_trace_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_trace_serializer
// Description : Scoreboard bench for rvfi_trace_serializer. The driver pushes
//               expected records into a queue as it issues commits; a monitor
//               pops and compares on every accepted stream transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_trace_serializer;
  import rvfi_trace_serializer_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  rvfi_instr_t [1:0]  rvfi;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [63:0]        out_order;
  logic [31:0]        out_insn;
  logic               out_trap;
  logic [63:0]        out_pc;
  logic [4:0]         out_rd_addr;
  logic [63:0]        out_rd_wdata;
  logic [63:0]        out_mem_addr;
  logic [7:0]         out_mem_wmask;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic               order_err;
  logic [63:0]        exp_order;
`ifdef RVFI_SER_TIMESTAMP_EN
  logic [31:0]        out_tstamp;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  rvfi_rec_t sb[$];

  always #5 clk = ~clk;

  rvfi_trace_serializer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rvfi_i          (rvfi),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_order_o     (out_order),
    .out_insn_o      (out_insn),
    .out_trap_o      (out_trap),
    .out_pc_o        (out_pc),
    .out_rd_addr_o   (out_rd_addr),
    .out_rd_wdata_o  (out_rd_wdata),
    .out_mem_addr_o  (out_mem_addr),
    .out_mem_wmask_o (out_mem_wmask),
`ifdef RVFI_SER_TIMESTAMP_EN
    .out_tstamp_o    (out_tstamp),
`endif
    .overflow_o      (overflow),
    .drop_cnt_o      (drop_cnt),
    .order_err_o     (order_err),
    .exp_order_o     (exp_order)
  );

  // Every field is derived from the order so a swapped or stale slot shows up.
  function automatic rvfi_rec_t mk(input logic [63:0] o);
    rvfi_rec_t r;
    r.order     = o;
    r.insn      = 32'h0000_0013 | {o[19:0], 12'h000};
    r.trap      = o[0];
    r.pc_rdata  = 64'h0000_0000_8000_0000 + (o << 2);
    r.rd_addr   = o[4:0];
    r.rd_wdata  = ~o;
    r.mem_addr  = {o[31:0], 32'hC0DE_0000};
    r.mem_wmask = o[7:0] ^ 8'hA5;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change #1 after posedge, so at negedge valid&ready
  // reflects exactly the transfer taken at the following edge.
  always @(negedge clk) begin
    rvfi_rec_t act;
    rvfi_rec_t exp;
    if (rst_n && out_valid && out_ready) begin
      act.order     = out_order;
      act.insn      = out_insn;
      act.trap      = out_trap;
      act.pc_rdata  = out_pc;
      act.rd_addr   = out_rd_addr;
      act.rd_wdata  = out_rd_wdata;
      act.mem_addr  = out_mem_addr;
      act.mem_wmask = out_mem_wmask;
      pops++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got order %0h expected none", out_order);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL record: got order %0h pc %0h wdata %0h expected order %0h pc %0h wdata %0h",
                   act.order, act.pc_rdata, act.rd_wdata, exp.order, exp.pc_rdata, exp.rd_wdata);
        end
      end
    end
  end

  // One commit cycle; acc is the hand-derived accept/drop outcome.
  task automatic cyc(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1, input bit acc);
    rvfi[0].valid = v[0];
    rvfi[0].rec   = mk(o0);
    rvfi[1].valid = v[1];
    rvfi[1].rec   = mk(o1);
    if (acc) begin
      if (v[0]) sb.push_back(mk(o0));
      if (v[1]) sb.push_back(mk(o1));
    end
    @(posedge clk); #1;
    rvfi[0].valid = 1'b0;
    rvfi[1].valid = 1'b0;
  endtask

  task automatic do_reset();
    out_ready     = 1'b0;
    rvfi[0].valid = 1'b0;
    rvfi[1].valid = 1'b0;
    rst_n         = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!out_valid && sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({name, "_valid_low"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int p0;
    rvfi = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_order", out_order, 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("rst_order_err", {63'd0, order_err}, 64'd0);
    chk("rst_exp_order", exp_order, 64'd0);

    // Single lane, one-cycle latency
    out_ready = 1'b1;
    cyc(2'b01, 64'd0, 64'd0, 1'b1);
    chk("single_valid_n1", {63'd0, out_valid}, 64'd1);
    cyc(2'b01, 64'd1, 64'd0, 1'b1);
    cyc(2'b01, 64'd2, 64'd0, 1'b1);
    drain("single");
    chk("single_order_err", {63'd0, order_err}, 64'd0);

    // Lane compaction
    do_reset();
    out_ready = 1'b1;
    cyc(2'b10, 64'd0, 64'd5, 1'b1);
    cyc(2'b11, 64'd6, 64'd7, 1'b1);
    drain("compact");
    chk("compact_order_err", {63'd0, order_err}, 64'd0);

    // Overflow: fill 8, drop a group of 2, then drain exactly 8
    do_reset();
    for (int g = 0; g < 4; g++) cyc(2'b11, 64'(2*g), 64'(2*g+1), 1'b1);
    chk("full_no_overflow", {63'd0, overflow}, 64'd0);
    cyc(2'b11, 64'd8, 64'd9, 1'b0);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd2);
    chk("ovf_head_order", out_order, 64'd0);
    p0 = pops;
    drain("ovf");
    chk("ovf_drained", 64'(pops - p0), 64'd8);
    chk("ovf_order_err", {63'd0, order_err}, 64'd0);

    // Simultaneous push/pop at full
    do_reset();
    for (int g = 0; g < 4; g++) cyc(2'b11, 64'(20+2*g), 64'(21+2*g), 1'b1);
    out_ready = 1'b1;
    cyc(2'b01, 64'd28, 64'd0, 1'b1);
    out_ready = 1'b0;
    chk("pushpop_no_overflow", {63'd0, overflow}, 64'd0);
    cyc(2'b01, 64'd29, 64'd0, 1'b0);
    chk("pushpop_still_full", {63'd0, overflow}, 64'd1);
    chk("pushpop_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    p0 = pops;
    drain("pushpop");
    chk("pushpop_drained", 64'(pops - p0), 64'd8);
    chk("pushpop_order_err", {63'd0, order_err}, 64'd0);

    // Order error, first capture sticks
    do_reset();
    out_ready = 1'b1;
    cyc(2'b01, 64'd10, 64'd0, 1'b1);
    cyc(2'b01, 64'd11, 64'd0, 1'b1);
    chk("oerr_none_yet", {63'd0, order_err}, 64'd0);
    cyc(2'b01, 64'd13, 64'd0, 1'b1);
    chk("oerr_flag", {63'd0, order_err}, 64'd1);
    chk("oerr_exp", exp_order, 64'd12);
    cyc(2'b01, 64'd14, 64'd0, 1'b1);
    cyc(2'b01, 64'd20, 64'd0, 1'b1);
    chk("oerr_exp_sticky", exp_order, 64'd12);
    drain("oerr");

    // Lane chaining inside one cycle
    do_reset();
    out_ready = 1'b1;
    cyc(2'b11, 64'd30, 64'd32, 1'b1);
    chk("chain_flag", {63'd0, order_err}, 64'd1);
    chk("chain_exp", exp_order, 64'd31);
    drain("chain");

    // Reset mid-drain
    do_reset();
    cyc(2'b11, 64'd40, 64'd41, 1'b1);
    cyc(2'b11, 64'd43, 64'd44, 1'b1);
    cyc(2'b01, 64'd45, 64'd0, 1'b1);
    chk("mid_valid", {63'd0, out_valid}, 64'd1);
    chk("mid_err_before", {63'd0, order_err}, 64'd1);
    do_reset();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_err", {63'd0, order_err}, 64'd0);
    chk("mid_rst_exp", exp_order, 64'd0);
    chk("mid_rst_order", out_order, 64'd0);
    out_ready = 1'b1;
    cyc(2'b01, 64'd100, 64'd0, 1'b1);
    chk("post_rst_err", {63'd0, order_err}, 64'd0);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
